// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned restoring divider with architectural HI/LO registers.
// Holds the pipeline with a stall while a division is in flight.
module divu_hilo_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [5:0] DIVU_CODE = 6'd27,
    parameter logic [5:0] MFHI_CODE = 6'd16,
    parameter logic [5:0] MFLO_CODE = 6'd18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       ALUOperation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic [2*WIDTH-1:0] step_s;
    logic               is_div_s;
    logic               is_mfhi_s;
    logic               is_mflo_s;

    // One restoring step: returns {rem_next, quo_next}. The shifted remainder
    // is WIDTH+1 bits; since rem < divisor it stays below 2*divisor, so the
    // top bit of the difference is a clean borrow (divisor 0 never borrows).
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (diff[WIDTH] == 1'b0) begin
            div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
    endfunction

    assign is_div_s  = op_valid & (ALUOperation == DIVU_CODE);
    assign is_mfhi_s = op_valid & (ALUOperation == MFHI_CODE);
    assign is_mflo_s = op_valid & (ALUOperation == MFLO_CODE);

    assign busy  = (state_r == ST_RUN);
    assign stall = busy & (is_div_s | is_mfhi_s | is_mflo_s);
    assign done  = done_r;

    // Next division step from the current iteration registers
    always_comb begin
        step_s = div_step(rem_r, quo_r, divisor_r);
    end

    // HI/LO read port; never exposes the in-flight remainder
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (is_mfhi_s) begin
            rd_data = hi_r;
        end else if (is_mflo_s) begin
            rd_data = lo_r;
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

    // Divider FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            count_r   <= COUNT_ZERO;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (is_div_s) begin
                        quo_r     <= src_a;
                        divisor_r <= src_b;
                        rem_r     <= {WIDTH{1'b0}};
                        count_r   <= COUNT_INIT;
                        state_r   <= ST_RUN;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {rem_r, quo_r} <= step_s;
                    if (count_r == COUNT_ZERO) begin
                        hi_r    <= step_s[2*WIDTH-1:WIDTH];
                        lo_r    <= step_s[WIDTH-1:0];
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        count_r <= count_r - COUNT_ONE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed self-checking bench for divu_hilo_unit: latency, results, stall,
// back-to-back issue and asynchronous abort.
`timescale 1ns/1ps
module tb_divu_hilo_unit;

    localparam logic [5:0] OP_DIVU = 6'd27;
    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;
    localparam logic [5:0] OP_ADD  = 6'd32;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [5:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    divu_hilo_unit dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .ALUOperation (alu_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .rd_data      (rd_data),
        .busy         (busy),
        .stall        (stall),
        .done         (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
    endtask

    // Count negedges while busy; optionally present add then a held mfhi
    task automatic wait_run(output int cyc, input bit hold_mf);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (hold_mf && cyc == 2) begin
                drive(1'b1, OP_ADD, 32'd1, 32'd2);
                #1 check("add_no_stall", {31'd0, stall}, 32'd0);
            end else if (hold_mf && cyc >= 3) begin
                drive(1'b1, OP_MFHI, 32'd0, 32'd0);
                #1 check("mfhi_stall", {31'd0, stall}, 32'd1);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input bit hold_mf);
        int cyc;
        @(negedge clk);
        drive(1'b1, OP_DIVU, a, b);
        @(negedge clk);
        drive(1'b0, OP_ADD, ~a, b ^ 32'h5a5a_a5a5);
        #1 check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_run(cyc, hold_mf);
        check("busy_cycles", cyc, 32'd32);
        check("done_pulse", {31'd0, done}, 32'd1);
        if (hold_mf) begin
            #1 check("done_stall_clear", {31'd0, stall}, 32'd0);
            check("done_mfhi_new", rd_data, exp_hi);
        end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1 check("mflo", rd_data, exp_lo);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1 check("mfhi", rd_data, exp_hi);
        check("mf_no_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1 check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int gap;
        int pulses;
        rst = 1'b1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1 check("rst_mfhi", rd_data, 32'd0);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1 check("rst_mflo", rd_data, 32'd0);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // divu code without op_valid must not start a division
        @(negedge clk);
        drive(1'b0, OP_DIVU, 32'd10, 32'd2);
        @(negedge clk);
        #1 check("invalid_no_accept", {31'd0, busy}, 32'd0);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        run_div(32'd1_000_003, 32'd1000, 32'd1000, 32'd3, 1'b1);

        // back-to-back: second divu issued in the DONE cycle
        @(negedge clk);
        drive(1'b1, OP_DIVU, 32'd1000, 32'd10);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        wait_run(cyc, 1'b0);
        check("b2b_first_done", {31'd0, done}, 32'd1);
        drive(1'b1, OP_DIVU, 32'd50, 32'd8);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1 check("b2b_no_gap", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        gap = 1;
        while (done !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_done_spacing", gap, 32'd33);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1 check("b2b_mflo", rd_data, 32'd6);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1 check("b2b_mfhi", rd_data, 32'd2);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);

        // asynchronous reset mid-division
        @(negedge clk);
        drive(1'b1, OP_DIVU, 32'd200, 32'd7);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1 check("abort_hi", rd_data, 32'd0);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1 check("abort_lo", rd_data, 32'd0);
        #1 rst = 1'b0;
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
